// File: rtl/servo_slew_planner.sv
// rtl/servo_slew_planner.sv - target-angle to PWM high-time planner with per-frame slew limit
//
// Accepts target angles, converts them to high-time counts and walks pw_out toward
// the target by at most STEP_MAX once per PWM frame.
//
// Ports:
//   clk_pwm    in   PWM clock (shared with the PWM generator)
//   rst        in   asynchronous active-low reset (shared with the PWM generator)
//   cmd_valid  in   target angle offered
//   cmd_deg    in   target angle in degrees, unsigned
//   cmd_ready  out  command can be accepted this cycle (low only in CALC)
//   pw_out     out  current high-time count, drives the PWM angle input
//   moving     out  pw_out differs from target
//   clamp_err  out  one-cycle pulse after accepting cmd_deg > MAX_DEG
//   frame_tick out  one-cycle pulse on the last cycle of each frame
module servo_slew_planner #(
    parameter int unsigned F           = 50,
    parameter int unsigned MIN_PW      = 25000,
    parameter int unsigned CNT_PER_DEG = 555,
    parameter int unsigned MAX_DEG     = 180,
    parameter int unsigned STEP_MAX    = 2775,
    parameter int unsigned INIT_DEG    = 90
) (
    input  logic        clk_pwm,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_deg,
    output logic        cmd_ready,
    output logic [31:0] pw_out,
    output logic        moving,
    output logic        clamp_err,
    output logic        frame_tick
);

    localparam int unsigned FRAME      = 50_000_000 / F;
    localparam int unsigned CW         = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME - 1);
    localparam logic [31:0] INIT_PW    = 32'(MIN_PW + INIT_DEG * CNT_PER_DEG);
    localparam logic [31:0] MIN_PW_W   = 32'(MIN_PW);
    localparam logic [31:0] CPD_W      = 32'(CNT_PER_DEG);
    localparam logic [31:0] STEP_W     = 32'(STEP_MAX);
    localparam logic [7:0]  MAX_DEG_B  = 8'(MAX_DEG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        MOVE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]     deg_q, deg_d;
    logic [31:0]    target_q, target_d;
    logic [31:0]    pw_q, pw_d;
    logic           moving_q, moving_d;
    logic           clamp_q, clamp_d;

    logic           accept;
    logic           tick;
    logic           up;
    logic [31:0]    diff;
    logic [31:0]    calc_target;

    assign cmd_ready   = (state_q != CALC);
    assign accept      = cmd_valid && cmd_ready;
    assign tick        = (frame_cnt_q == FRAME_LAST);
    assign calc_target = MIN_PW_W + {24'd0, deg_q} * CPD_W;

    assign pw_out     = pw_q;
    assign moving     = moving_q;
    assign clamp_err  = clamp_q;
    assign frame_tick = tick;

    always_comb begin
        state_d     = state_q;
        deg_d       = deg_q;
        target_d    = target_q;
        pw_d        = pw_q;
        clamp_d     = 1'b0;
        frame_cnt_d = tick ? '0 : frame_cnt_q + CW'(1);

        up   = (target_q >= pw_q);
        diff = up ? (target_q - pw_q) : (pw_q - target_q);

        // Slew runs in every state against the registered target, so a tick
        // landing in CALC still uses the previous target.
        if (tick && (diff != 32'd0)) begin
            if (diff <= STEP_W) begin
                pw_d = target_q;
            end else if (up) begin
                pw_d = pw_q + STEP_W;
            end else begin
                pw_d = pw_q - STEP_W;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    deg_d   = (cmd_deg > MAX_DEG_B) ? MAX_DEG_B : cmd_deg;
                    clamp_d = (cmd_deg > MAX_DEG_B);
                    state_d = CALC;
                end
            end
            CALC: begin
                target_d = calc_target;
                // Compare against the post-edge pw_out so a tick in this cycle
                // that lands exactly on the new target does not leave us in MOVE.
                state_d  = (calc_target != pw_d) ? MOVE : IDLE;
            end
            MOVE: begin
                if (accept) begin
                    deg_d   = (cmd_deg > MAX_DEG_B) ? MAX_DEG_B : cmd_deg;
                    clamp_d = (cmd_deg > MAX_DEG_B);
                    state_d = CALC;
                end else if (tick && (diff <= STEP_W)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        moving_d = (pw_d != target_d);
    end

    always_ff @(posedge clk_pwm or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            deg_q       <= 8'(INIT_DEG);
            target_q    <= INIT_PW;
            pw_q        <= INIT_PW;
            moving_q    <= 1'b0;
            clamp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            deg_q       <= deg_d;
            target_q    <= target_d;
            pw_q        <= pw_d;
            moving_q    <= moving_d;
            clamp_q     <= clamp_d;
        end
    end

endmodule

// File: tb/tb_servo_slew_planner.sv
// tb/tb_servo_slew_planner.sv - self-checking bench for servo_slew_planner
module tb_servo_slew_planner;

    localparam int F_TB  = 1_000_000;
    localparam int FRAME = 50_000_000 / F_TB;
    localparam int MINP  = 25000;
    localparam int CPD   = 555;
    localparam int STEP  = 2775;
    localparam int INIT  = MINP + 90 * CPD;

    logic        clk_pwm;
    logic        rst;
    logic        cmd_valid;
    logic [7:0]  cmd_deg;
    logic        cmd_ready;
    logic [31:0] pw_out;
    logic        moving;
    logic        clamp_err;
    logic        frame_tick;

    int total;
    int bad;

    int m_cyc;
    int m_pw;
    int m_tgt;
    bit m_ready;
    bit m_clamp;
    bit pend;
    int pend_deg;
    bit last_tick;

    servo_slew_planner #(.F(F_TB)) dut (
        .clk_pwm    (clk_pwm),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_deg    (cmd_deg),
        .cmd_ready  (cmd_ready),
        .pw_out     (pw_out),
        .moving     (moving),
        .clamp_err  (clamp_err),
        .frame_tick (frame_tick)
    );

    initial clk_pwm = 1'b0;
    always #5 clk_pwm = ~clk_pwm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of the reference model followed by a full output check.
    task automatic cycle();
        bit acc;
        bit tk;
        int d;
        acc = cmd_valid && m_ready;
        tk  = ((m_cyc % FRAME) == FRAME - 1);
        if (tk) begin
            d = m_tgt - m_pw;
            if (d > STEP)  d = STEP;
            if (d < -STEP) d = -STEP;
            m_pw = m_pw + d;
        end
        if (pend) m_tgt = MINP + pend_deg * CPD;
        pend = acc;
        if (acc) pend_deg = (int'(cmd_deg) > 180) ? 180 : int'(cmd_deg);
        m_clamp   = acc && (int'(cmd_deg) > 180);
        m_ready   = !acc;
        last_tick = tk;
        m_cyc++;
        @(posedge clk_pwm);
        #1;
        chk("pw_out",     pw_out,     m_pw);
        chk("moving",     moving,     (m_pw != m_tgt));
        chk("clamp_err",  clamp_err,  m_clamp);
        chk("cmd_ready",  cmd_ready,  m_ready);
        chk("frame_tick", frame_tick, ((m_cyc % FRAME) == FRAME - 1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            last_tick = 1'b0;
            for (int i = 0; i < FRAME + 1 && !last_tick; i++) cycle();
        end
    endtask

    task automatic send(input int deg);
        cmd_deg   = 8'(deg);
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
    endtask

    // Asserted between edges so the checks below see the asynchronous effect.
    task automatic do_reset();
        cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_pw_out",     pw_out,     INIT);
        chk("rst_moving",     moving,     0);
        chk("rst_clamp_err",  clamp_err,  0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_cmd_ready",  cmd_ready,  1);
        @(posedge clk_pwm);
        #1;
        rst       = 1'b1;
        m_cyc     = 0;
        m_pw      = INIT;
        m_tgt     = INIT;
        m_ready   = 1'b1;
        m_clamp   = 1'b0;
        pend      = 1'b0;
        pend_deg  = 90;
        last_tick = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_deg   = 8'd0;
        @(posedge clk_pwm);
        #1;

        // Reset state and first tick position
        do_reset();
        run(FRAME + 5);

        // 100 deg from reset: two ticks to reach 80500
        do_reset();
        send(100);
        run_ticks(1);
        chk("s2_tick1", pw_out, 77725);
        run_ticks(1);
        chk("s2_tick2", pw_out, 80500);
        cycle();
        chk("s2_settled", moving, 0);

        // Clamped command, 18 ticks to the top
        do_reset();
        send(200);
        chk("s3_clamp_pulse", clamp_err, 1);
        cycle();
        chk("s3_clamp_off", clamp_err, 0);
        run_ticks(17);
        chk("s3_not_yet", moving, 1);
        run_ticks(1);
        chk("s3_top", pw_out, 124900);

        // Mid-slew retarget down to 0 deg
        do_reset();
        send(100);
        run_ticks(1);
        send(0);
        run_ticks(1);
        chk("s4_tick", pw_out, INIT);
        run_ticks(18);
        chk("s4_bottom", pw_out, MINP);
        run(3);

        // Same target as current position
        do_reset();
        send(90);
        run(FRAME + 3);
        chk("s5_hold", pw_out, INIT);

        // 255 clamps to 180
        do_reset();
        send(255);
        chk("s255_clamp", clamp_err, 1);
        run_ticks(18);
        chk("s255_top", pw_out, 124900);

        // Reset mid-slew, then frame phase restarts from zero
        do_reset();
        send(180);
        run_ticks(13);
        chk("s6_mid", pw_out, 111025);
        do_reset();
        run(2 * FRAME + 2);

        // Randomized commands, some held through CALC
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 15) == 0);
            cmd_deg   = 8'($urandom_range(0, 255));
            cycle();
        end
        cmd_valid = 1'b0;
        run(25 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
